// File: rtl/s_output_port_ctrl.sv
// South output port controller: credit-gated wormhole transfer from four input
// queues onto the south link, locking the link to one input for a whole packet.
module s_output_port_ctrl #(
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_n_i,
  input  logic              grant_w_i,
  input  logic              grant_e_i,
  input  logic              grant_l_i,
  input  logic [FLIT_W-1:0] n_flit_i,
  input  logic [FLIT_W-1:0] w_flit_i,
  input  logic [FLIT_W-1:0] e_flit_i,
  input  logic [FLIT_W-1:0] l_flit_i,
  input  logic              n_tail_i,
  input  logic              w_tail_i,
  input  logic              e_tail_i,
  input  logic              l_tail_i,
  input  logic              credit_return_i,
  output logic [FLIT_W-1:0] s_flit_o,
  output logic              s_valid_o,
  output logic              s_tail_o,
  output logic              n_pop_o,
  output logic              w_pop_o,
  output logic              e_pop_o,
  output logic              l_pop_o,
  output logic              rr_downstream_credit_o,
  output logic              rr_change_order_o,
  output logic [3:0]        credit_cnt_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

  // Port index order: N=0, W=1, E=2, L=3
  logic [3:0]        grant;
  logic [3:0]        tail;
  logic [FLIT_W-1:0] flit [4];
  logic [3:0]        pop;

  assign grant   = {grant_l_i, grant_e_i, grant_w_i, grant_n_i};
  assign tail    = {l_tail_i, e_tail_i, w_tail_i, n_tail_i};
  assign flit[0] = n_flit_i;
  assign flit[1] = w_flit_i;
  assign flit[2] = e_flit_i;
  assign flit[3] = l_flit_i;

  state_t            state_reg, state_next;
  logic [1:0]        owner_reg, owner_next;
  logic [3:0]        credit_reg, credit_next;
  logic [FLIT_W-1:0] flit_reg;
  logic              valid_reg;
  logic              tail_reg;
  logic              change_reg;
  logic              err_reg;

  logic [1:0] prio_sel;
  logic [1:0] sel;
  logic       xfer;
  logic       credit_ok;
  logic       multi_grant;
  logic       err_set;

  assign credit_ok   = (credit_reg != 4'd0);
  assign multi_grant = ((grant & (grant - 4'd1)) != 4'd0);

  // Lowest index wins, giving N > W > E > L.
  always_comb begin
    prio_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (grant[i]) prio_sel = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    sel        = prio_sel;
    xfer       = 1'b0;
    case (state_reg)
      IDLE: begin
        sel  = prio_sel;
        xfer = (|grant) && credit_ok;
        if (xfer && !tail[sel]) begin
          state_next = LOCKED;
          owner_next = sel;
        end
      end
      LOCKED: begin
        // Other ports' grants are ignored until the owner's tail goes out.
        sel  = owner_reg;
        xfer = grant[owner_reg] && credit_ok;
        if (xfer && tail[sel]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credit_next = credit_reg;
    err_set     = (state_reg == IDLE) && multi_grant;
    if (xfer && !credit_return_i) begin
      credit_next = credit_reg - 4'd1;
    end else if (!xfer && credit_return_i) begin
      if (credit_reg >= CREDIT_MAX) err_set = 1'b1;
      else                          credit_next = credit_reg + 4'd1;
    end
  end

  // Pops are forced low during reset so no flit is lost from an input queue.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pop
      assign pop[gi] = xfer && !reset && (sel == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_reg <= CREDIT_MAX;
      flit_reg   <= '0;
      valid_reg  <= 1'b0;
      tail_reg   <= 1'b0;
      change_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      valid_reg  <= xfer;
      change_reg <= xfer && tail[sel];
      if (xfer) begin
        flit_reg <= flit[sel];
        tail_reg <= tail[sel];
      end
      if (err_set) err_reg <= 1'b1;
    end
  end

  assign n_pop_o                = pop[0];
  assign w_pop_o                = pop[1];
  assign e_pop_o                = pop[2];
  assign l_pop_o                = pop[3];
  assign s_flit_o               = flit_reg;
  assign s_valid_o              = valid_reg;
  assign s_tail_o               = tail_reg;
  assign rr_change_order_o      = change_reg;
  assign rr_downstream_credit_o = credit_ok;
  assign credit_cnt_o           = credit_reg;
  assign err_o                  = err_reg;

endmodule

// File: tb/tb_s_output_port_ctrl.sv
// Directed and random stimulus for s_output_port_ctrl against a packet-level
// reference model of credits, port locking and the output register.
module tb_s_output_port_ctrl;

  localparam int FW = 32;
  localparam int CR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          grant_n_i, grant_w_i, grant_e_i, grant_l_i;
  logic [FW-1:0] n_flit_i, w_flit_i, e_flit_i, l_flit_i;
  logic          n_tail_i, w_tail_i, e_tail_i, l_tail_i;
  logic          credit_return_i;
  logic [FW-1:0] s_flit_o;
  logic          s_valid_o, s_tail_o;
  logic          n_pop_o, w_pop_o, e_pop_o, l_pop_o;
  logic          rr_downstream_credit_o, rr_change_order_o;
  logic [3:0]    credit_cnt_o;
  logic          err_o;

  s_output_port_ctrl #(.FLIT_W(FW), .CREDITS(CR)) dut (
    .clk(clk), .reset(reset),
    .grant_n_i(grant_n_i), .grant_w_i(grant_w_i),
    .grant_e_i(grant_e_i), .grant_l_i(grant_l_i),
    .n_flit_i(n_flit_i), .w_flit_i(w_flit_i),
    .e_flit_i(e_flit_i), .l_flit_i(l_flit_i),
    .n_tail_i(n_tail_i), .w_tail_i(w_tail_i),
    .e_tail_i(e_tail_i), .l_tail_i(l_tail_i),
    .credit_return_i(credit_return_i),
    .s_flit_o(s_flit_o), .s_valid_o(s_valid_o), .s_tail_o(s_tail_o),
    .n_pop_o(n_pop_o), .w_pop_o(w_pop_o), .e_pop_o(e_pop_o), .l_pop_o(l_pop_o),
    .rr_downstream_credit_o(rr_downstream_credit_o),
    .rr_change_order_o(rr_change_order_o),
    .credit_cnt_o(credit_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packet-level view of the port
  int            m_cred   = CR;
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  bit            m_err    = 1'b0;
  logic [FW-1:0] m_flit   = '0;
  bit            m_valid  = 1'b0;
  bit            m_tail   = 1'b0;
  bit            m_chg    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pops mid-cycle, check registers after the edge.
  task automatic step(input logic [3:0] g, input logic [3:0] t, input logic ret,
                      input logic rst, input logic [FW-1:0] fixed);
    logic [FW-1:0] f [4];
    int win;
    int ngrant;
    logic [3:0] exp_pop;
    for (int i = 0; i < 4; i++) f[i] = (fixed != '0) ? fixed : FW'($urandom);
    grant_n_i = g[0]; grant_w_i = g[1]; grant_e_i = g[2]; grant_l_i = g[3];
    n_tail_i  = t[0]; w_tail_i  = t[1]; e_tail_i  = t[2]; l_tail_i  = t[3];
    n_flit_i  = f[0]; w_flit_i  = f[1]; e_flit_i  = f[2]; l_flit_i  = f[3];
    credit_return_i = ret;
    reset           = rst;

    win = -1;
    ngrant = 0;
    for (int i = 0; i < 4; i++) if (g[i]) ngrant++;
    if (!rst && m_cred > 0) begin
      if (!m_locked) begin
        for (int i = 0; i < 4; i++) if (g[i] && win < 0) win = i;
      end else if (g[m_owner]) begin
        win = m_owner;
      end
    end
    exp_pop = (win >= 0) ? 4'(1 << win) : 4'b0000;

    @(negedge clk);
    chk("pop", 64'({l_pop_o, e_pop_o, w_pop_o, n_pop_o}), 64'(exp_pop));

    if (rst) begin
      m_cred = CR; m_locked = 1'b0; m_owner = 0; m_err = 1'b0;
      m_flit = '0; m_valid = 1'b0; m_tail = 1'b0; m_chg = 1'b0;
    end else begin
      if (!m_locked && ngrant > 1) m_err = 1'b1;
      if (win >= 0 && !ret)       m_cred = m_cred - 1;
      else if (win < 0 && ret) begin
        if (m_cred == CR) m_err = 1'b1;
        else              m_cred = m_cred + 1;
      end
      m_valid = (win >= 0);
      m_chg   = (win >= 0) && t[win];
      if (win >= 0) begin
        m_flit = f[win];
        m_tail = t[win];
        if (!m_locked && !t[win]) begin
          m_locked = 1'b1;
          m_owner  = win;
        end else if (m_locked && t[win]) begin
          m_locked = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    chk("credit_cnt", 64'(credit_cnt_o), 64'(m_cred));
    chk("rr_credit", 64'(rr_downstream_credit_o), 64'(m_cred != 0));
    chk("s_valid", 64'(s_valid_o), 64'(m_valid));
    chk("change_order", 64'(rr_change_order_o), 64'(m_chg));
    chk("err", 64'(err_o), 64'(m_err));
    chk("s_flit", 64'(s_flit_o), 64'(m_flit));
    if (m_valid || rst) chk("s_tail", 64'(s_tail_o), 64'(m_tail));
  endtask

  initial begin
    logic [3:0] g, t;
    logic ret, rst;
    reset = 1'b1;
    grant_n_i = 0; grant_w_i = 0; grant_e_i = 0; grant_l_i = 0;
    n_tail_i = 0; w_tail_i = 0; e_tail_i = 0; l_tail_i = 0;
    n_flit_i = '0; w_flit_i = '0; e_flit_i = '0; l_flit_i = '0;
    credit_return_i = 0;
    @(posedge clk);
    #1;

    // Reset with all grants high: no pops, reset values
    step(4'hF, 4'h0, 1'b0, 1'b1, '0);
    step(4'h0, 4'h0, 1'b0, 1'b0, '0);

    // Single-flit packet on L
    step(4'b1000, 4'b1000, 1'b0, 1'b0, 32'hA5A5A5A5);
    chk("single_flit_value", 64'(s_flit_o), 64'h0000_0000_A5A5_A5A5);
    step(4'h0, 4'h0, 1'b1, 1'b0, '0);

    // Three-flit W packet, E raised mid-packet
    step(4'b0010, 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0110, 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0110, 4'b0110, 1'b0, 1'b0, '0);
    chk("three_flit_credit", 64'(credit_cnt_o), 64'd1);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b1, 1'b0, '0);

    // Credit exhaustion on N, then resume on a single return
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, '0);
    step(4'b0001, 4'b0000, 1'b0, 1'b0, '0);
    step(4'h0, 4'h0, 1'b1, 1'b0, '0);
    step(4'b0001, 4'b0001, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(4'h0, 4'h0, 1'b1, 1'b0, '0);

    // Transfer plus return at 2 holds; return at full saturates and errors
    step(4'b1000, 4'b1000, 1'b0, 1'b0, '0);
    step(4'b1000, 4'b1000, 1'b0, 1'b0, '0);
    step(4'b1000, 4'b1000, 1'b1, 1'b0, '0);
    step(4'h0, 4'h0, 1'b1, 1'b0, '0);
    step(4'h0, 4'h0, 1'b1, 1'b0, '0);
    step(4'h0, 4'h0, 1'b1, 1'b0, '0);

    // Two grants in IDLE, then reset while locked
    step(4'h0, 4'h0, 1'b0, 1'b1, '0);
    step(4'b0101, 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0101, 4'b0000, 1'b0, 1'b1, '0);
    step(4'b0100, 4'b0100, 1'b0, 1'b0, '0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      g = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) g = 4'h0;
      for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 2) == 0);
      ret = (m_cred < CR) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step(g, t, ret, rst, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s_output_port_ctrl.md
S_OUTPUT_PORT_CTRL -- requirements
Module: s_output_port_ctrl

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit payload width in bits.
REQ-002 SHALL have parameter CREDITS, default 4, downstream buffer depth in flits (2..15).
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- grant_n_i / grant_w_i / grant_e_i / grant_l_i  input  1 each  south-output grant from the south round-robin processor.
- n_flit_i / w_flit_i / e_flit_i / l_flit_i  input  FLIT_W each  head-of-queue flit per input port.
- n_tail_i / w_tail_i / e_tail_i / l_tail_i  input  1 each  head flit is a packet tail.
- credit_return_i  input  1  downstream buffer freed one slot.
- s_flit_o  output  FLIT_W  registered flit to the south link.
- s_valid_o  output  1  s_flit_o valid this cycle.
- s_tail_o  output  1  s_flit_o is a tail.
- n_pop_o / w_pop_o / e_pop_o / l_pop_o  output  1 each  combinational dequeue to the input buffer.
- rr_downstream_credit_o  output  1  credit available, to the arbiter's downstream-credit input.
- rr_change_order_o  output  1  one-cycle pulse advancing round-robin order.
- credit_cnt_o  output  4  current credit count.
- err_o  output  1  sticky protocol error.

Function
REQ-005 SHALL keep credit_cnt in 0..CREDITS; rr_downstream_credit_o = (credit_cnt != 0), from the register only.
REQ-006 SHALL implement FSM states IDLE and LOCKED, plus a 2-bit owner register (N=0, W=1, E=2, L=3).
REQ-007 Transfer condition, IDLE: any grant high and credit_cnt != 0. Selected port: the high grant; if more than one is high, fixed priority N>W>E>L.
REQ-008 Transfer condition, LOCKED: the owner's grant high and credit_cnt != 0. Non-owner grants are ignored and never pop.
REQ-009 On transfer, the selected port's pop_o SHALL be high in the same cycle (combinational); all other pops are low.
REQ-010 On transfer, the selected flit and tail SHALL be registered; s_valid_o=1 the next cycle. Latency is 1 cycle; otherwise s_valid_o=0 and s_flit_o holds its last value.
REQ-011 IDLE transfer with tail=0 -> LOCKED, owner=selected port. Tail=1 (single-flit packet) -> remain IDLE.
REQ-012 LOCKED transfer with tail=1 -> IDLE. Tail=0 -> remain LOCKED.
REQ-013 rr_change_order_o SHALL pulse high for exactly one cycle, in the cycle after any tail transfer (aligned with s_tail_o).
REQ-014 Credit update per cycle:
- transfer only: -1.
- credit_return_i only: +1.
- both: unchanged.
- neither: unchanged.
REQ-015 credit_return_i with credit_cnt==CREDITS and no transfer: counter SHALL saturate at CREDITS and set err_o.
REQ-016 err_o SHALL also set when more than one grant is high in IDLE. err_o is cleared only by reset.
REQ-017 credit_cnt==0: no transfer, no pop, FSM and owner hold. A return in the same cycle takes effect next cycle only.
REQ-018 Back-to-back transfers SHALL sustain one flit per cycle while credits remain.

Reset
REQ-019 On reset the block SHALL set: state=IDLE, owner=0, credit_cnt=CREDITS, s_flit_o=0, s_valid_o=0, s_tail_o=0, rr_change_order_o=0, err_o=0.
REQ-020 During a reset cycle, all pops SHALL be 0 regardless of grants.
REQ-021 Reset mid-packet SHALL abandon the packet (IDLE, credits restored) with no change_order pulse.

Verification
REQ-022 Single-flit: grant_l_i=1, l_tail_i=1, l_flit_i=0xA5A5A5A5 -> l_pop_o=1 same cycle; next cycle s_valid_o=1, s_flit_o=0xA5A5A5A5, s_tail_o=1, rr_change_order_o=1; credit_cnt_o 4->3.
REQ-023 Three-flit packet on W with grant_e_i also raised mid-packet -> only w_pop_o fires for 3 cycles; e_pop_o=0; change_order pulses once, after the tail; credit 4->1.
REQ-024 Credit exhaustion: 5 consecutive body flits from N, no returns -> 4 transfers; rr_downstream_credit_o=0 after the 4th; 5th flit held with n_pop_o=0. One credit_return_i -> transfer resumes the next cycle.
REQ-025 Simultaneous transfer and credit_return_i at credit_cnt=2 -> credit_cnt stays 2. credit_return_i at 4 with no transfer -> stays 4, err_o=1.
REQ-026 grant_n_i and grant_e_i both high in IDLE -> N served, err_o=1. Reset asserted while LOCKED -> next cycle IDLE, credit_cnt_o=4, err_o=0, rr_change_order_o=0.
